// File: rtl/instr_fetch_if.sv
// Instruction-memory bus between the fetch stage and instruction memory.
//
// Handshake: the fetch stage raises req for exactly one cycle with addr
// holding the byte address of the word wanted. There is no ready: memory
// must accept every request. Memory answers with rvalid high for one cycle,
// one or more cycles after the request, with rdata carrying the word.
// Only one request is ever outstanding.
//
// Signals:
//   req    - fetch request (driven by fetch stage)
//   addr   - 64-bit fetch address (driven by fetch stage)
//   rvalid - response valid (driven by memory)
//   rdata  - 32-bit instruction word (driven by memory)
interface instr_fetch_if;
  logic        req;
  logic [63:0] addr;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req,
    output addr,
    input  rvalid,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output rvalid,
    output rdata
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction-fetch stage. Owns the 64-bit PC, issues single-outstanding
// fetches to instruction memory and presents {instr, pc_addr} with a valid
// flag to the IF/ID register. Branch redirects from EX/MEM override
// everything and may leave a fetch in flight, whose response is discarded.
//
// Ports:
//   clk         - clock, rising edge
//   rst         - asynchronous active-low reset
//   stall       - IF/ID not accepting this cycle
//   redirect    - taken branch/jump, highest priority
//   redirect_pc - new fetch target, low two bits ignored
//   imem        - instruction memory bus (master side)
//   instr       - registered instruction word
//   pc_addr     - registered PC of instr
//   instr_valid - output register holds a live instruction
//   fsm_state   - current fetch state (0=REQ, 1=WAIT, 2=DROP)
module instr_fetch #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter int unsigned PC_STEP   = 4,
  parameter logic [31:0] NOP_INSTR = 32'hD503201F
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                redirect,
  input  logic [63:0]         redirect_pc,
  instr_fetch_if.master       imem,
  output logic [31:0]         instr,
  output logic [63:0]         pc_addr,
  output logic                instr_valid,
  output logic [1:0]          fsm_state
);

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  localparam logic [63:0] PC_INC = 64'(PC_STEP);

  state_t      state;
  state_t      state_d;
  logic [63:0] pc;
  logic [63:0] pc_d;
  logic [31:0] instr_d;
  logic [63:0] pc_addr_d;
  logic        valid_d;
  logic        issue;
  logic        consume;

  // A request only goes out when the output register is empty or is being
  // drained this cycle, so a response always finds the register free.
  assign issue   = (state == ST_REQ) && !redirect && (!instr_valid || !stall);
  assign consume = instr_valid && !stall && !redirect;

  assign imem.req  = issue && rst;
  assign imem.addr = pc;
  assign fsm_state = state;

  always_comb begin
    state_d   = state;
    pc_d      = pc;
    instr_d   = instr;
    pc_addr_d = pc_addr;
    valid_d   = instr_valid;

    if (consume) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end

    if (redirect) begin
      pc_d    = redirect_pc & ~64'h3;
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
      // In WAIT the outstanding response must be thrown away; if it is
      // arriving on this very edge it is simply ignored here.
      if (state == ST_WAIT) begin
        state_d = imem.rvalid ? ST_REQ : ST_DROP;
      end
    end else begin
      unique case (state)
        ST_REQ: begin
          // rvalid here would be a protocol error and is ignored.
          if (issue) state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (imem.rvalid) begin
            instr_d   = imem.rdata;
            pc_addr_d = pc;
            valid_d   = 1'b1;
            pc_d      = pc + PC_INC;
            state_d   = ST_REQ;
          end
        end
        ST_DROP: begin
          if (imem.rvalid) state_d = ST_REQ;
        end
        default: state_d = ST_REQ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_REQ;
      pc          <= RESET_PC;
      instr       <= NOP_INSTR;
      pc_addr     <= '0;
      instr_valid <= 1'b0;
    end else begin
      state       <= state_d;
      pc          <= pc_d;
      instr       <= instr_d;
      pc_addr     <= pc_addr_d;
      instr_valid <= valid_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch: memory model with programmable latency,
// scoreboard of expected {instr, pc} entries and directed scenario tasks.
module tb_instr_fetch;

  localparam logic [31:0] NOP = 32'hD503201F;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic [31:0] instr;
  logic [63:0] pc_addr;
  logic        instr_valid;
  logic [1:0]  fsm_state;

  instr_fetch_if imem();

  instr_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem        (imem.master),
    .instr       (instr),
    .pc_addr     (pc_addr),
    .instr_valid (instr_valid),
    .fsm_state   (fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [95:0] exp_q[$];

  // ---------------- memory model ----------------
  int          mem_k = 1;
  int          mem_cnt = 0;
  bit          mem_pend = 1'b0;
  logic [63:0] mem_addr = '0;
  int          drop_set = 0;   // responses the bench expects to be discarded
  int          drop_used = 0;
  int          flush_cnt = 0;  // live output entries killed by a redirect
  int          flushed = 0;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a == 64'h0) return 32'h8B020020;
    if (a == 64'h4) return 32'h8B030041;
    return a[31:0] ^ 32'h5A5A_0F0F;
  endfunction

  always @(negedge clk) begin
    if (imem.req === 1'b1) begin
      mem_pend = 1'b1;
      mem_addr = imem.addr;
      mem_cnt  = mem_k;
    end
  end

  always @(posedge clk) begin
    #1;
    imem.rvalid = 1'b0;
    if (mem_pend) begin
      mem_cnt = mem_cnt - 1;
      if (mem_cnt <= 0) begin
        mem_pend    = 1'b0;
        imem.rvalid = 1'b1;
        imem.rdata  = mem_word(mem_addr);
        if (drop_used < drop_set) drop_used = drop_used + 1;
        else if (rst) exp_q.push_back({mem_word(mem_addr), mem_addr});
      end
    end
  end

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [95:0] exp;
    while (flushed < flush_cnt) begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      flushed = flushed + 1;
    end
    if (rst && instr_valid && !stall && !redirect) begin
      checks = checks + 1;
      if (exp_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL sb_unexpected: got instr=%h pc=%h, required nothing", instr, pc_addr);
      end else begin
        exp = exp_q.pop_front();
        if ({instr, pc_addr} !== exp) begin
          errors = errors + 1;
          $display("FAIL sb_data: got instr=%h pc=%h, required instr=%h pc=%h",
                   instr, pc_addr, exp[95:64], exp[63:0]);
        end
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(negedge clk);
    checks = checks + 4;
    if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b required 0", instr_valid); end
    if (instr !== NOP) begin errors++; $display("FAIL rst_instr: got %h required %h", instr, NOP); end
    if (pc_addr !== 64'h0) begin errors++; $display("FAIL rst_pc_addr: got %h required 0", pc_addr); end
    if (imem.req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b required 0", imem.req); end
  endtask

  task automatic test_basic();
    step(); rst = 1'b1;
    @(negedge clk);
    checks = checks + 2;
    if (imem.req !== 1'b1) begin errors++; $display("FAIL basic_req0: got %b required 1", imem.req); end
    if (imem.addr !== 64'h0) begin errors++; $display("FAIL basic_addr0: got %h required 0", imem.addr); end
    step(); @(negedge clk);
    checks = checks + 2;
    if (imem.req !== 1'b0) begin errors++; $display("FAIL basic_wait_req: got %b required 0", imem.req); end
    if (instr_valid !== 1'b0) begin errors++; $display("FAIL basic_wait_valid: got %b required 0", instr_valid); end
    step(); @(negedge clk);
    checks = checks + 3;
    if (instr_valid !== 1'b1) begin errors++; $display("FAIL basic_valid0: got %b required 1", instr_valid); end
    if (pc_addr !== 64'h0) begin errors++; $display("FAIL basic_pc0: got %h required 0", pc_addr); end
    if (imem.addr !== 64'h4 || imem.req !== 1'b1) begin errors++; $display("FAIL basic_addr4: got req=%b addr=%h required req=1 addr=4", imem.req, imem.addr); end
    step(); @(negedge clk);
    checks = checks + 1;
    if (instr_valid !== 1'b0) begin errors++; $display("FAIL basic_gap: got %b required 0", instr_valid); end
    step(); @(negedge clk);
    checks = checks + 2;
    if (instr_valid !== 1'b1 || pc_addr !== 64'h4) begin errors++; $display("FAIL basic_pc4: got valid=%b pc=%h required valid=1 pc=4", instr_valid, pc_addr); end
    if (imem.addr !== 64'h8 || imem.req !== 1'b1) begin errors++; $display("FAIL basic_addr8: got req=%b addr=%h required req=1 addr=8", imem.req, imem.addr); end
  endtask

  task automatic test_stall();
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      if (i == 0) stall = 1'b1;
      @(negedge clk);
      checks = checks + 2;
      if (instr_valid !== 1'b1 || pc_addr !== 64'h8 || instr !== mem_word(64'h8)) begin
        errors++;
        $display("FAIL stall_hold%0d: got valid=%b pc=%h instr=%h required valid=1 pc=8 instr=%h",
                 i, instr_valid, pc_addr, instr, mem_word(64'h8));
      end
      if (imem.req !== 1'b0) begin errors++; $display("FAIL stall_req%0d: got %b required 0", i, imem.req); end
    end
  endtask

  task automatic test_redirect_wait();
    step(); stall = 1'b0; mem_k = 3;
    @(negedge clk);
    checks = checks + 1;
    if (imem.req !== 1'b1 || imem.addr !== 64'hC) begin errors++; $display("FAIL stall_release: got req=%b addr=%h required req=1 addr=c", imem.req, imem.addr); end
    step();
    step(); redirect = 1'b1; redirect_pc = 64'h103; drop_set++;
    @(negedge clk);
    checks = checks + 1;
    if (imem.req !== 1'b0) begin errors++; $display("FAIL rdw_req: got %b required 0", imem.req); end
    step(); redirect = 1'b0;
    @(negedge clk);
    checks = checks + 2;
    if (instr_valid !== 1'b0) begin errors++; $display("FAIL rdw_valid: got %b required 0", instr_valid); end
    if (imem.req !== 1'b0) begin errors++; $display("FAIL rdw_drop_req: got %b required 0", imem.req); end
    step(); @(negedge clk);
    checks = checks + 1;
    if (imem.req !== 1'b1 || imem.addr !== 64'h100) begin errors++; $display("FAIL rdw_addr: got req=%b addr=%h required req=1 addr=100", imem.req, imem.addr); end
  endtask

  task automatic test_redirect_rvalid();
    step();
    step(); drop_set++;
    step(); redirect = 1'b1; redirect_pc = 64'h200;
    @(negedge clk);
    checks = checks + 1;
    if (imem.req !== 1'b0) begin errors++; $display("FAIL rdr_req: got %b required 0", imem.req); end
    step(); redirect = 1'b0; mem_k = 1;
    @(negedge clk);
    checks = checks + 2;
    if (instr_valid !== 1'b0) begin errors++; $display("FAIL rdr_valid: got %b required 0", instr_valid); end
    if (imem.req !== 1'b1 || imem.addr !== 64'h200) begin errors++; $display("FAIL rdr_addr: got req=%b addr=%h required req=1 addr=200", imem.req, imem.addr); end
    step();
    step(); @(negedge clk);
    checks = checks + 1;
    if (instr_valid !== 1'b1 || pc_addr !== 64'h200) begin errors++; $display("FAIL rdr_out: got valid=%b pc=%h required valid=1 pc=200", instr_valid, pc_addr); end
  endtask

  task automatic test_wrap();
    step();
    // The redirect kills the instruction sitting in the output register.
    step(); redirect = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFE; flush_cnt++;
    @(negedge clk);
    checks = checks + 1;
    if (imem.req !== 1'b0) begin errors++; $display("FAIL wrap_redir_req: got %b required 0", imem.req); end
    step(); redirect = 1'b0;
    @(negedge clk);
    checks = checks + 2;
    if (instr_valid !== 1'b0 || instr !== NOP) begin errors++; $display("FAIL wrap_flush: got valid=%b instr=%h required valid=0 instr=%h", instr_valid, instr, NOP); end
    if (imem.req !== 1'b1 || imem.addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL wrap_top_addr: got req=%b addr=%h required req=1 addr=fffffffffffffffc", imem.req, imem.addr); end
    step();
    step(); mem_k = 3;
    @(negedge clk);
    checks = checks + 2;
    if (instr_valid !== 1'b1 || pc_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL wrap_pc_addr: got valid=%b pc=%h required valid=1 pc=fffffffffffffffc", instr_valid, pc_addr); end
    if (imem.addr !== 64'h0) begin errors++; $display("FAIL wrap_next_addr: got %h required 0", imem.addr); end
  endtask

  task automatic test_reset_drop();
    step(); redirect = 1'b1; redirect_pc = 64'h300; drop_set++;
    step(); redirect = 1'b0;
    @(negedge clk);
    checks = checks + 1;
    if (imem.req !== 1'b0) begin errors++; $display("FAIL rd_drop_req: got %b required 0", imem.req); end
    #1 rst = 1'b0;
    #1;
    checks = checks + 2;
    if (instr_valid !== 1'b0 || instr !== NOP) begin errors++; $display("FAIL rd_async: got valid=%b instr=%h required valid=0 instr=%h", instr_valid, instr, NOP); end
    if (imem.req !== 1'b0) begin errors++; $display("FAIL rd_rst_req: got %b required 0", imem.req); end
    step(); step();
    step(); rst = 1'b1; mem_k = 1;
    @(negedge clk);
    checks = checks + 2;
    if (imem.req !== 1'b1 || imem.addr !== 64'h0) begin errors++; $display("FAIL rd_restart: got req=%b addr=%h required req=1 addr=0", imem.req, imem.addr); end
    if (instr_valid !== 1'b0) begin errors++; $display("FAIL rd_stale: got %b required 0", instr_valid); end
    step();
    step(); @(negedge clk);
    checks = checks + 1;
    if (instr_valid !== 1'b1 || pc_addr !== 64'h0 || instr !== 32'h8B020020) begin errors++; $display("FAIL rd_first: got valid=%b pc=%h instr=%h required valid=1 pc=0 instr=8b020020", instr_valid, pc_addr, instr); end
    // Reset while a live instruction is held: it must vanish before any edge.
    #1 rst = 1'b0;
    #1;
    checks = checks + 1;
    if (instr_valid !== 1'b0 || instr !== NOP || pc_addr !== 64'h0) begin errors++; $display("FAIL rd_async_live: got valid=%b instr=%h pc=%h required valid=0 instr=%h pc=0", instr_valid, instr, pc_addr, NOP); end
    step();
    step(); rst = 1'b1;
    @(negedge clk);
    checks = checks + 1;
    if (imem.req !== 1'b1 || imem.addr !== 64'h0) begin errors++; $display("FAIL rd_restart2: got req=%b addr=%h required req=1 addr=0", imem.req, imem.addr); end
    step();
    step(); @(negedge clk);
    checks = checks + 1;
    if (instr_valid !== 1'b1 || pc_addr !== 64'h0) begin errors++; $display("FAIL rd_second: got valid=%b pc=%h required valid=1 pc=0", instr_valid, pc_addr); end
    #1;
    checks = checks + 1;
    if (exp_q.size() != 0) begin errors++; $display("FAIL sb_drain: got %0d pending required 0", exp_q.size()); end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- sequence + report ----------------
  initial begin
    rst         = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    test_reset();
    test_basic();
    test_stall();
    test_redirect_wait();
    test_redirect_rvalid();
    test_wrap();
    test_reset_drop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
